// File: rtl/posicionador_frota.sv
// rtl/posicionador_frota.sv - fleet placement controller for Batalha Naval
// Steps each player through direction, orientation and bow X/Y per ship, then validates and writes.
module posicionador_frota #(
  parameter int                     GRID_W       = 4,
  parameter int                     BOARD_SIZE   = 10,
  parameter int                     NUM_TYPES    = 5,
  parameter logic [3*NUM_TYPES-1:0] FLEET_COUNTS = 15'h1295,
  parameter int                     NUM_ORIENT   = 5,
  localparam int                    TYPE_W       = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              enter,
  input  logic              select,
  input  logic              mode,
  input  logic              conflito,
  input  logic              valida_ack,
  output logic [GRID_W-1:0] X1,
  output logic [GRID_W-1:0] Y1,
  output logic [TYPE_W-1:0] tipo,
  output logic [2:0]        qtd,
  output logic              direcao,
  output logic [2:0]        orientacao,
  output logic              jogador,
  output logic              valida,
  output logic              grava,
  output logic              erro,
  output logic              ready,
  output logic [2:0]        estado
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIRECAO = 3'd1,
    ORIENT  = 3'd2,
    DEF_X   = 3'd3,
    DEF_Y   = 3'd4,
    VALIDA  = 3'd5,
    GRAVA   = 3'd6,
    PRONTO  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [GRID_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic [TYPE_W-1:0] tipo_q, tipo_d;
  logic [2:0]        qtd_q, qtd_d, ori_q, ori_d;
  logic              dir_q, dir_d, jog_q, jog_d, mode_q, mode_d;
  logic              valida_q, valida_d, grava_q, grava_d, erro_q, erro_d, ready_q, ready_d;
  logic              ent_s1_q, ent_s1_d, ent_s2_q, ent_s2_d, ent_prev_q, ent_prev_d;
  logic              sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_prev_q, sel_prev_d;
  logic              ent_ev, sel_ev;
  logic [2:0]        cur_count;
  logic [3:0]        qtd_inc;

  always_comb begin
    ent_s1_d   = enter;
    ent_s2_d   = ent_s1_q;
    ent_prev_d = ent_s2_q;
    sel_s1_d   = select;
    sel_s2_d   = sel_s1_q;
    sel_prev_d = sel_s2_q;
    ent_ev     = ent_prev_q & ~ent_s2_q;
    // enter has priority: a coincident select press is dropped
    sel_ev     = sel_prev_q & ~sel_s2_q & ~ent_ev;
    cur_count  = 3'd0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (tipo_q == TYPE_W'(t)) cur_count = FLEET_COUNTS[3*t +: 3];
    end
    qtd_inc  = {1'b0, qtd_q} + 4'd1;

    state_d  = state_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    tipo_d   = tipo_q;
    qtd_d    = qtd_q;
    ori_d    = ori_q;
    dir_d    = dir_q;
    jog_d    = jog_q;
    mode_d   = mode_q;
    valida_d = valida_q;
    grava_d  = grava_q;
    erro_d   = erro_q;
    ready_d  = ready_q;

    if (enable) begin
      grava_d = 1'b0;
      erro_d  = 1'b0;
      case (state_q)
        IDLE: begin
          state_d = DIRECAO;
          mode_d  = mode;
        end
        DIRECAO: begin
          if (ent_ev) state_d = ORIENT;
          else if (sel_ev) dir_d = ~dir_q;
        end
        ORIENT: begin
          if (ent_ev) state_d = DEF_X;
          else if (sel_ev) ori_d = (ori_q == 3'(NUM_ORIENT-1)) ? 3'd0 : ori_q + 3'd1;
        end
        DEF_X: begin
          if (ent_ev) state_d = DEF_Y;
          else if (sel_ev) x1_d = (x1_q == GRID_W'(BOARD_SIZE-1)) ? '0 : x1_q + 1'b1;
        end
        DEF_Y: begin
          if (ent_ev) begin
            state_d  = VALIDA;
            valida_d = 1'b1;
          end else if (sel_ev) begin
            y1_d = (y1_q == GRID_W'(BOARD_SIZE-1)) ? '0 : y1_q + 1'b1;
          end
        end
        VALIDA: begin
          if (valida_ack) begin
            valida_d = 1'b0;
            if (conflito) begin
              erro_d  = 1'b1;
              state_d = DEF_X;
            end else begin
              grava_d = 1'b1;
              state_d = GRAVA;
            end
          end
        end
        GRAVA: begin
          // counters advance only as GRAVA is left so the memory write sees the current ship
          state_d = DIRECAO;
          if (qtd_inc < {1'b0, cur_count}) begin
            qtd_d = qtd_inc[2:0];
          end else begin
            qtd_d = 3'd0;
            if (tipo_q != TYPE_W'(NUM_TYPES-1)) begin
              tipo_d = tipo_q + 1'b1;
            end else if (jog_q || !mode_q) begin
              state_d = PRONTO;
              ready_d = 1'b1;
            end else begin
              jog_d  = 1'b1;
              tipo_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      x1_q       <= '0;
      y1_q       <= '0;
      tipo_q     <= '0;
      qtd_q      <= 3'd0;
      ori_q      <= 3'd0;
      dir_q      <= 1'b0;
      jog_q      <= 1'b0;
      mode_q     <= 1'b0;
      valida_q   <= 1'b0;
      grava_q    <= 1'b0;
      erro_q     <= 1'b0;
      ready_q    <= 1'b0;
      ent_s1_q   <= 1'b1;
      ent_s2_q   <= 1'b1;
      ent_prev_q <= 1'b1;
      sel_s1_q   <= 1'b1;
      sel_s2_q   <= 1'b1;
      sel_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      tipo_q     <= tipo_d;
      qtd_q      <= qtd_d;
      ori_q      <= ori_d;
      dir_q      <= dir_d;
      jog_q      <= jog_d;
      mode_q     <= mode_d;
      valida_q   <= valida_d;
      grava_q    <= grava_d;
      erro_q     <= erro_d;
      ready_q    <= ready_d;
      ent_s1_q   <= ent_s1_d;
      ent_s2_q   <= ent_s2_d;
      ent_prev_q <= ent_prev_d;
      sel_s1_q   <= sel_s1_d;
      sel_s2_q   <= sel_s2_d;
      sel_prev_q <= sel_prev_d;
    end
  end

  assign X1         = x1_q;
  assign Y1         = y1_q;
  assign tipo       = tipo_q;
  assign qtd        = qtd_q;
  assign direcao    = dir_q;
  assign orientacao = ori_q;
  assign jogador    = jog_q;
  assign valida     = valida_q;
  assign grava      = grava_q;
  assign erro       = erro_q;
  assign ready      = ready_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_posicionador_frota.sv
// tb/tb_posicionador_frota.sv - self-checking bench for posicionador_frota
// Scripted field/step vectors, corner sequences, then randomized full games against a fleet model.
module tb_posicionador_frota;

  logic       clk = 1'b0;
  logic       reset, enable, enter, select, mode, conflito, valida_ack;
  logic [3:0] X1, Y1;
  logic [2:0] tipo, qtd, orientacao, estado;
  logic       direcao, jogador, valida, grava, erro, ready;

  posicionador_frota dut (
    .clk(clk), .reset(reset), .enable(enable), .enter(enter), .select(select),
    .mode(mode), .conflito(conflito), .valida_ack(valida_ack),
    .X1(X1), .Y1(Y1), .tipo(tipo), .qtd(qtd), .direcao(direcao),
    .orientacao(orientacao), .jogador(jogador), .valida(valida), .grava(grava),
    .erro(erro), .ready(ready), .estado(estado)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int op;
    int est;
    int dir;
    int ori;
    int x;
  } vec_t;

  typedef struct {
    int jog;
    int tp;
    int q;
  } slot_t;

  vec_t  tbl[20];
  int    counts[5] = '{5, 2, 2, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op: 0 select, 1 enter, 2 both together
  task automatic press(input int op);
    if (op != 0) enter = 1'b0;
    if (op != 1) select = 1'b0;
    repeat (3) tick();
    enter  = 1'b1;
    select = 1'b1;
    repeat (3) tick();
  endtask

  task automatic ack(input logic c);
    valida_ack = 1'b1;
    conflito   = c;
    tick();
    valida_ack = 1'b0;
    conflito   = 1'b0;
  endtask

  task automatic wait_valida();
    int n = 0;
    while (!valida && n < 10) begin
      tick();
      n++;
    end
    check("wait_valida", {31'd0, valida}, 32'd1);
  endtask

  function automatic vec_t mk(int op, int est, int dir, int ori, int x);
    vec_t v;
    v.op = op; v.est = est; v.dir = dir; v.ori = ori; v.x = x;
    return v;
  endfunction

  task automatic run_game(input logic m);
    slot_t plan[$];
    slot_t s;
    int    mx, my, mdir, mori, n;
    plan.delete();
    for (int p = 0; p < (m ? 2 : 1); p++)
      for (int t = 0; t < 5; t++)
        for (int q = 0; q < counts[t]; q++) begin
          s.jog = p; s.tp = t; s.q = q;
          plan.push_back(s);
        end
    reset = 1'b0;
    mode  = m;
    tick();
    reset = 1'b1;
    tick();
    check("game_start_state", {29'd0, estado}, 32'd1);
    mx = 0; my = 0; mdir = 0; mori = 0;
    foreach (plan[i]) begin
      n = $urandom_range(0, 2);
      repeat (n) press(0);
      mdir = mdir ^ (n & 1);
      press(1);
      n = $urandom_range(0, 6);
      repeat (n) press(0);
      mori = (mori + n) % 5;
      press(1);
      n = $urandom_range(0, 11);
      repeat (n) press(0);
      mx = (mx + n) % 10;
      press(1);
      n = $urandom_range(0, 11);
      repeat (n) press(0);
      my = (my + n) % 10;
      press(1);
      wait_valida();
      if ($urandom_range(0, 3) == 0) begin
        ack(1'b1);
        check("game_erro", {31'd0, erro}, 32'd1);
        check("game_erro_state", {29'd0, estado}, 32'd3);
        press(1);
        press(1);
        wait_valida();
      end
      check("game_not_ready", {31'd0, ready}, 32'd0);
      ack(1'b0);
      check("game_grava", {31'd0, grava}, 32'd1);
      check("game_slot", {jogador, 3'b0, tipo, 1'b0, qtd}, {plan[i].jog[0], 3'b0, plan[i].tp[2:0], 1'b0, plan[i].q[2:0]});
      check("game_fields", {direcao, 1'b0, orientacao, X1, Y1}, {mdir[0], 1'b0, mori[2:0], mx[3:0], my[3:0]});
      tick();
      check("game_grava_fall", {31'd0, grava}, 32'd0);
    end
    check("game_ready", {31'd0, ready}, 32'd1);
    check("game_pronto", {29'd0, estado}, 32'd7);
    check("game_jogador", {31'd0, jogador}, {31'd0, m});
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; enter = 1'b1; select = 1'b1;
    mode = 1'b1; conflito = 1'b0; valida_ack = 1'b0;
    tick();
    check("reset_outputs", {X1, Y1, tipo, qtd, direcao, orientacao, jogador, valida, grava, erro, ready, estado},
          32'd0);

    reset  = 1'b1;
    enable = 1'b1;
    tick();
    check("idle_to_direcao", {29'd0, estado}, 32'd1);

    tbl[0] = mk(0, 1, 1, 0, 0);
    tbl[1] = mk(2, 2, 1, 0, 0);
    for (int k = 1; k <= 6; k++) tbl[1+k] = mk(0, 2, 1, k % 5, 0);
    tbl[8] = mk(1, 3, 1, 1, 0);
    for (int k = 1; k <= 10; k++) tbl[8+k] = mk(0, 3, 1, 1, k % 10);
    tbl[19] = mk(1, 4, 1, 1, 0);
    foreach (tbl[i]) begin
      press(tbl[i].op);
      check($sformatf("vec%0d", i), estado * 1000 + direcao * 100 + orientacao * 10 + X1,
            tbl[i].est * 1000 + tbl[i].dir * 100 + tbl[i].ori * 10 + tbl[i].x);
    end

    repeat (3) press(0);
    check("y_count", {28'd0, Y1}, 32'd3);
    press(1);
    check("enter_valida", {28'd0, valida, estado}, {28'd0, 1'b1, 3'd5});

    enable = 1'b0;
    ack(1'b0);
    check("frozen_valida", {28'd0, valida, estado}, {28'd0, 1'b1, 3'd5});
    enable = 1'b1;

    ack(1'b1);
    check("conflict_erro", {28'd0, erro, estado}, {28'd0, 1'b1, 3'd3});
    check("conflict_keep", {valida, direcao, orientacao, X1, Y1, qtd}, {1'b0, 1'b1, 3'd1, 4'd0, 4'd3, 3'd0});
    tick();
    check("erro_one_cycle", {31'd0, erro}, 32'd0);
    press(1);
    press(1);
    wait_valida();
    ack(1'b0);
    check("clean_grava", {grava, 1'b0, estado, tipo, qtd}, {1'b1, 1'b0, 3'd6, 3'd0, 3'd0});
    tick();
    check("after_grava", {grava, 1'b0, estado, tipo, qtd}, {1'b0, 1'b0, 3'd1, 3'd0, 3'd1});

    repeat (4) press(1);
    check("second_valida", {29'd0, estado}, 32'd5);
    reset = 1'b0;
    tick();
    check("reset_in_valida", {X1, Y1, tipo, qtd, direcao, orientacao, jogador, valida, grava, erro, ready, estado},
          32'd0);
    reset = 1'b1;

    run_game(1'b1);
    run_game(1'b0);
    run_game($urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/posicionador_frota.md
# posicionador_frota

Parametrised ship-placement controller for Batalha Naval: walks each player through direction, orientation, X and Y selection for every ship of a configurable fleet. It performs a handshake with the external conflict validator and issues a one-cycle write strobe to the board memory of the active player. It sits between the debounced pushbuttons and the validator/memory, and hands off to the game-execution block via `ready`.

## Interface
- `GRID_W`, 4: width of X1/Y1.
- `BOARD_SIZE`, 10: coordinates wrap from BOARD_SIZE-1 to 0; 2..2^GRID_W.
- `NUM_TYPES`, 5: ship types, 0..NUM_TYPES-1; TYPE_W = clog2(NUM_TYPES), min 1.
- `FLEET_COUNTS`, 15'h1295: packed 3 bits per type, type t at [3t+2:3t]; default 5,2,2,1,1 for types 0..4; each count 1..7.
- `NUM_ORIENT`, 5: orientation wraps NUM_ORIENT-1 -> 0; 1..8.
- Clocking: one clock; reset is synchronous and active-low.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `enable` in 1: 0 freezes the FSM and all registers except the synchronizers.
- `enter` in 1: debounced button, active-low; a press advances the step.
- `select` in 1: debounced button, active-low; a press increments the current field.
- `mode` in 1: 0 = Player vs CPU, 1 = Player vs Player; latched when leaving IDLE.
- `conflito` in 1: validator result, 1 = conflict; sampled only with `valida_ack`.
- `valida_ack` in 1: validator result valid.
- `X1`, `Y1` out GRID_W: bow coordinates.
- `tipo` out TYPE_W: current ship type.
- `qtd` out 3: ships of `tipo` already stored.
- `direcao` out 1: 0 horizontal, 1 vertical.
- `orientacao` out 3: orientation index.
- `jogador` out 1: board being filled.
- `valida` out 1: validation request.
- `grava` out 1: one-cycle memory write strobe.
- `erro` out 1: one-cycle conflict pulse.
- `ready` out 1: both fleets placed; start game.
- `estado` out 3: FSM state, for display.

## Operation
- States: IDLE=0, DIRECAO=1, ORIENT=2, DEF_X=3, DEF_Y=4, VALIDA=5, GRAVA=6, PRONTO=7.
- Button events: 2-flop synchronizer plus a previous-sample flop (all reset to 1). An event is previous=1 and current=0, one cycle per press. Only processed when enable=1.
- If enter and select events fall in the same cycle, enter wins and select is dropped.
- IDLE: enable=1 -> DIRECAO; latch `mode`.
- DIRECAO: select toggles direcao; enter -> ORIENT.
- ORIENT: select increments orientacao with wrap; enter -> DEF_X.
- DEF_X and DEF_Y: select increments X1 or Y1 with wrap at BOARD_SIZE-1. Enter moves DEF_X -> DEF_Y and DEF_Y -> VALIDA.
- VALIDA: valida=1 is held; buttons are ignored.
  - ack with conflito=0 -> GRAVA.
  - ack with conflito=1 -> erro pulse, then DEF_X; X1/Y1/direcao/orientacao are kept.
- GRAVA: grava=1 for exactly one cycle, then:
  - If qtd+1 < count[tipo]: qtd+1 -> DIRECAO.
  - Else qtd=0. If tipo < NUM_TYPES-1: tipo+1 -> DIRECAO.
  - Else (fleet complete): if jogador=1 or latched mode=0 -> PRONTO. Otherwise jogador=1, tipo=0 -> DIRECAO.
- PRONTO: ready=1 is held until reset; buttons are ignored.
- Field values persist across ships; they are cleared only by reset.

## Timing
- Reset (sampled with reset=0 at a rising edge; takes priority over enable): state IDLE.
  - X1, Y1, tipo, qtd, direcao, orientacao, jogador, valida, grava, erro, ready all become 0.
  - Synchronizers become 1.
- Button latency: edge 0 is the first to sample the low level. The field or state change is visible after edge 2. Holding the button low produces no further events.
- `valida` rises on the edge entering VALIDA and falls on the edge leaving it.
- `valida_ack` asserted in the entry cycle is accepted: the result is registered on the next edge.
- `grava` is high during the single GRAVA cycle. tipo/qtd/jogador update on the edge that leaves GRAVA, so the memory sees the pre-update values while `grava` is high.
- `ready` rises on the edge entering PRONTO.
- enable=0 mid-VALIDA: valida stays high and the ack is ignored until enable returns.
- Reset mid-operation discards any partial fleet.

## Test plan
- Default params, mode=1, 22 placements, each acked with conflito=0:
  - grava pulses 22 times.
  - jogador goes 0 -> 1 after the 11th grava.
  - tipo sequence per player: 0×5, 1×2, 2×2, 3, 4.
  - ready=1 after the 22nd grava.
- mode=0, 11 clean placements -> ready=1, jogador stays 0.
- In DEF_X, 10 select presses -> X1 counts 1..9, then wraps to 0.
- In ORIENT, 6 presses -> orientacao 1,2,3,4,0,1.
- In VALIDA, ack with conflito=1:
  - erro pulses once and the FSM returns to DEF_X with X1/Y1 unchanged.
  - qtd unchanged.
  - Re-ack with conflito=0 -> grava.
- Simultaneous enter+select in DIRECAO -> ORIENT, direcao unchanged.
- reset=0 during VALIDA -> every output is 0 and state is IDLE after that edge.
